prefetch_unit: RTL and testbench

PREFETCH_UNIT -- requirements
Module: prefetch_unit

---
 rtl/prefetch_pkg.sv | 13 +
 rtl/prefetch_unit_fifo.sv | 68 ++++++
 rtl/prefetch_unit.sv | 132 +++++++++++++
 tb/tb_prefetch_unit.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/prefetch_pkg.sv
// Shared types and constants for the instruction prefetch unit.
package prefetch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [3:0]  BUS_MASK_ALL     = 4'b1111;

endpackage

// File: rtl/prefetch_unit_fifo.sv
// Small synchronous FIFO with flush; the head entry is read straight from the register array.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic [WIDTH-1:0]         din_i,
    output logic [WIDTH-1:0]         dout_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop_i && (count_q != '0);
        do_push  = push_i && ((count_q != CNT_FULL) || do_pop);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
            if (do_push && !do_pop)      count_d = count_q + CNT_ONE;
            else if (do_pop && !do_push) count_d = count_q - CNT_ONE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; contents are qualified by count.
    always_ff @(posedge clk) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= din_i;
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CNT_FULL);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/prefetch_unit.sv
// Instruction prefetcher: one outstanding bus read at a time feeding a small instruction queue.
module prefetch_unit
    import prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        reset_i,
    output logic        sel_o,
    output logic [31:0] addr_o,
    output logic        we_o,
    output logic [3:0]  wr_mask_o,
    input  logic [31:0] data_in_i,
    input  logic        ack_i,
    output logic        instr_valid_o,
    output logic [31:0] instr_o,
    output logic [31:0] instr_pc_o,
    input  logic        instr_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] CNT_DEPTH = CW'(DEPTH);

    state_e      state_q, state_d;
    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic        sel_q, sel_d;
    logic [31:0] addr_q, addr_d;

    logic          fifo_push, fifo_pop, fifo_flush;
    logic [63:0]   fifo_din, fifo_dout;
    logic          fifo_full, fifo_empty;
    logic [CW-1:0] fifo_count;
    logic [31:0]   redirect_pc_aligned;
    logic          can_issue;

    assign redirect_pc_aligned = {redirect_pc_i[31:2], 2'b00};
    assign can_issue           = (fifo_count < CNT_DEPTH);
    assign fifo_din            = {addr_q, data_in_i};

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        sel_d      = sel_q;
        addr_d     = addr_q;
        fifo_push  = 1'b0;
        fifo_flush = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (redirect_i) begin
                    fifo_flush = 1'b1;
                    fetch_pc_d = redirect_pc_aligned;
                end else if (can_issue) begin
                    sel_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (redirect_i) begin
                    // A redirect makes the in-flight word stale; drop it when it lands.
                    fifo_flush = 1'b1;
                    fetch_pc_d = redirect_pc_aligned;
                    if (ack_i) begin
                        sel_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DRAIN;
                    end
                end else if (ack_i) begin
                    fifo_push  = !fifo_full;
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    sel_d      = 1'b0;
                    state_d    = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (redirect_i) fetch_pc_d = redirect_pc_aligned;
                if (ack_i) begin
                    sel_d   = 1'b0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                sel_d   = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign fifo_pop = !fifo_empty && instr_ready_i && !redirect_i;

    always_ff @(posedge clk or posedge reset_i) begin
        if (reset_i) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            sel_q      <= 1'b0;
            addr_q     <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
        end
    end

    sync_fifo #(
        .WIDTH (64),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (reset_i),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .flush_i (fifo_flush),
        .din_i   (fifo_din),
        .dout_o  (fifo_dout),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign sel_o         = sel_q;
    assign addr_o        = addr_q;
    assign we_o          = 1'b0;
    assign wr_mask_o     = BUS_MASK_ALL;
    assign instr_valid_o = !fifo_empty;
    assign instr_pc_o    = fifo_dout[63:32];
    assign instr_o       = fifo_dout[31:0];

endmodule

// File: tb/tb_prefetch_unit.sv
// Randomized bench for prefetch_unit checked against a queue-level model of the fetch stream.
module tb_prefetch_unit;
    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic        clk;
    logic        reset_i;
    logic        sel_o;
    logic [31:0] addr_o;
    logic        we_o;
    logic [3:0]  wr_mask_o;
    logic [31:0] data_in_i;
    logic        ack_i;
    logic        instr_valid_o;
    logic [31:0] instr_o;
    logic [31:0] instr_pc_o;
    logic        instr_ready_i;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;

    prefetch_unit #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk           (clk),
        .reset_i       (reset_i),
        .sel_o         (sel_o),
        .addr_o        (addr_o),
        .we_o          (we_o),
        .wr_mask_o     (wr_mask_o),
        .data_in_i     (data_in_i),
        .ack_i         (ack_i),
        .instr_valid_o (instr_valid_o),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o),
        .instr_ready_i (instr_ready_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Memory image seen by the bus slave: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'hC001_D00D;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: words the stream should deliver, in order, and the next fetch address.
    logic [31:0] exp_q[$];
    logic [31:0] next_req;
    bit          req_live;
    bit          prev_valid, prev_sel, prev_ack, prev_redirect;
    logic [31:0] prev_addr;
    int          prev_size;
    int          n_deliv, n_req;
    bit          slv_busy;
    int          slv_wait;

    initial begin
        reset_i = 1'b1; ack_i = 1'b0; data_in_i = '0;
        instr_ready_i = 1'b0; redirect_i = 1'b0; redirect_pc_i = '0;
        exp_q.delete(); next_req = RPC; req_live = 0; prev_valid = 0;
        prev_sel = 0; prev_ack = 0; prev_redirect = 0; prev_addr = '0; prev_size = 0;
        n_deliv = 0; n_req = 0; slv_busy = 0; slv_wait = 0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_sel", 32'(sel_o), 32'd0);
        chk("reset_addr", addr_o, 32'd0);
        chk("reset_valid", 32'(instr_valid_o), 32'd0);
        chk("reset_we", 32'(we_o), 32'd0);
        chk("reset_mask", 32'(wr_mask_o), 32'hF);
        @(posedge clk); #1;

        for (int cyc = 0; cyc < 1900; cyc++) begin
            int phase;
            bit new_req;
            phase = (cyc < 300) ? 0 : (cyc < 380) ? 1 : 2;

            // Drive this cycle's inputs just after the rising edge.
            reset_i = (phase == 2) && ($urandom_range(0, 119) == 0);
            if (reset_i) begin
                slv_busy = 0; ack_i = 1'b0; redirect_i = 1'b0;
            end else begin
                if (sel_o && !slv_busy) begin
                    slv_busy = 1;
                    slv_wait = $urandom_range(0, 3);
                end
                if (slv_busy) begin
                    ack_i = (slv_wait == 0);
                    if (slv_wait > 0) slv_wait--;
                    if (ack_i) slv_busy = 0;
                end else begin
                    ack_i = ($urandom_range(0, 9) == 0);
                end
                redirect_i = (phase == 2) && ($urandom_range(0, 9) == 0);
            end
            data_in_i     = ack_i ? mem_word(addr_o) : $urandom;
            redirect_pc_i = $urandom_range(0, 4095);
            case (phase)
                0:       instr_ready_i = ($urandom_range(0, 3) != 0);
                1:       instr_ready_i = 1'b0;
                default: instr_ready_i = $urandom_range(0, 1);
            endcase

            @(negedge clk);
            if (reset_i) begin
                chk("rst_sel", 32'(sel_o), 32'd0);
                chk("rst_addr", addr_o, 32'd0);
                chk("rst_valid", 32'(instr_valid_o), 32'd0);
                $display("reset pulse cyc=%0d", cyc);
                exp_q.delete(); next_req = RPC; req_live = 0; prev_valid = 0;
            end else begin
                chk("we", 32'(we_o), 32'd0);
                chk("mask", 32'(wr_mask_o), 32'hF);
                chk("valid", 32'(instr_valid_o), 32'(exp_q.size() != 0));
                if (exp_q.size() != 0) begin
                    chk("head_pc", instr_pc_o, exp_q[0]);
                    chk("head_data", instr_o, mem_word(exp_q[0]));
                end
                if (prev_valid) begin
                    if (prev_sel && !prev_ack) begin
                        chk("sel_hold", 32'(sel_o), 32'd1);
                        chk("addr_hold", addr_o, prev_addr);
                    end else if (prev_sel && prev_ack) begin
                        chk("sel_gap", 32'(sel_o), 32'd0);
                    end else if (!prev_redirect && prev_size < DEPTH) begin
                        chk("sel_issue", 32'(sel_o), 32'd1);
                    end else begin
                        chk("sel_noissue", 32'(sel_o), 32'd0);
                    end
                    new_req = sel_o && (!prev_sel || prev_ack);
                    if (new_req) begin
                        chk("req_addr", addr_o, next_req);
                        req_live = 1;
                        n_req++;
                    end
                end
                prev_size     = exp_q.size();
                prev_sel      = sel_o;
                prev_ack      = ack_i;
                prev_addr     = addr_o;
                prev_redirect = redirect_i;

                if (redirect_i) begin
                    $display("redirect cyc=%0d pc=%h", cyc, redirect_pc_i);
                    exp_q.delete();
                    next_req = {redirect_pc_i[31:2], 2'b00};
                    req_live = 0;
                end else begin
                    if (exp_q.size() != 0 && instr_ready_i) begin
                        $display("deliver cyc=%0d pc=%h instr=%h", cyc, instr_pc_o, instr_o);
                        void'(exp_q.pop_front());
                        n_deliv++;
                    end
                    if (ack_i && sel_o && req_live) begin
                        exp_q.push_back(addr_o);
                        next_req = addr_o + 32'd4;
                        req_live = 0;
                    end
                end
                prev_valid = 1;
            end
            @(posedge clk); #1;
        end

        chk("enough_deliveries", 32'(n_deliv >= 100), 32'd1);
        chk("enough_requests", 32'(n_req >= 200), 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
